answer_checker: RTL

ANSWER_CHECKER -- requirements
Module: answer_checker

---
 rtl/answer_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/answer_checker.sv
// -----------------------------------------------------------------------------
// answer_checker
//
// Keypad answer checker. The user types up to four decimal digits, which are
// accumulated into a binary value. ENTER compares that value against the
// answer supplied by the arithmetic stage:
//   - a correct entry opens the lock until CLEAR is pressed;
//   - MAX_FAIL consecutive wrong entries lock the keypad out for LOCK_CYCLES
//     clock cycles.
// All outputs are registered.
//
// Parameters
//   MAX_FAIL     consecutive wrong entries that trigger lockout (1..3)
//   LOCK_CYCLES  lockout duration in clock cycles (>= 1)
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, 10 CLEAR, 11 ENTER, 12-15 ignored
//   correct_ans  expected answer (16 bits, max 6561)
//   ans_valid    correct_ans is stable and may be used
//   entry_val    binary value of the digits typed so far
//   digit_cnt    number of digits accepted so far (0-4)
//   unlock       high while the lock is open
//   fail_pulse   one-cycle pulse per wrong entry
//   fail_cnt     consecutive wrong entries
//   locked       high while locked out
// -----------------------------------------------------------------------------
module answer_checker #(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] correct_ans,
  input  logic        ans_valid,
  output logic [13:0] entry_val,
  output logic [2:0]  digit_cnt,
  output logic        unlock,
  output logic        fail_pulse,
  output logic [1:0]  fail_cnt,
  output logic        locked
);

  localparam logic [1:0] S_ENTRY   = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_OPEN    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;

  // +1 keeps the counter at least one bit wide when LOCK_CYCLES is 1.
  localparam int              CNT_W      = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]      FAIL_LIMIT = 2'(MAX_FAIL);

  logic [1:0]       state;
  logic [CNT_W-1:0] lock_cnt;

  logic       is_digit;
  logic       is_clear;
  logic       is_enter;
  logic       ans_match;
  logic [1:0] fail_next;

  // Codes 12-15 decode to none of these, so they fall through as no-ops.
  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign is_clear  = key_valid && (key_code == KEY_CLEAR);
  assign is_enter  = key_valid && (key_code == KEY_ENTER);
  assign ans_match = ({2'b00, entry_val} == correct_ans);
  assign fail_next = fail_cnt + 2'd1;

  // Main FSM. fail_pulse defaults low every cycle so it can only ever be a
  // single-cycle pulse raised from CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ENTRY;
      entry_val  <= 14'd0;
      digit_cnt  <= 3'd0;
      unlock     <= 1'b0;
      fail_pulse <= 1'b0;
      fail_cnt   <= 2'd0;
      locked     <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      fail_pulse <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (is_digit) begin
            // A fifth digit is dropped rather than wrapping the value.
            if (digit_cnt < 3'd4) begin
              entry_val <= entry_val * 14'd10 + {10'd0, key_code};
              digit_cnt <= digit_cnt + 3'd1;
            end
          end else if (is_clear) begin
            entry_val <= 14'd0;
            digit_cnt <= 3'd0;
          end else if (is_enter && (digit_cnt != 3'd0) && ans_valid) begin
            state <= S_CHECK;
          end
        end

        // Single-cycle compare; any key arriving now is simply not decoded.
        S_CHECK: begin
          entry_val <= 14'd0;
          digit_cnt <= 3'd0;
          if (ans_match) begin
            state    <= S_OPEN;
            unlock   <= 1'b1;
            fail_cnt <= 2'd0;
          end else begin
            fail_pulse <= 1'b1;
            fail_cnt   <= fail_next;
            if (fail_next == FAIL_LIMIT) begin
              state    <= S_LOCKOUT;
              locked   <= 1'b1;
              lock_cnt <= LOCK_LOAD;
            end else begin
              state <= S_ENTRY;
            end
          end
        end

        S_OPEN: begin
          if (is_clear) begin
            state     <= S_ENTRY;
            unlock    <= 1'b0;
            entry_val <= 14'd0;
            digit_cnt <= 3'd0;
          end
        end

        // Counter is loaded with LOCK_CYCLES-1 so that, counting the expiry
        // cycle itself, locked stays high for exactly LOCK_CYCLES cycles.
        S_LOCKOUT: begin
          if (lock_cnt == '0) begin
            state    <= S_ENTRY;
            locked   <= 1'b0;
            fail_cnt <= 2'd0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end

        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule
